// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode constants and the pipeline-control FSM state type.
package riscv_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;
endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: EX load whose rd feeds an ID source register.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic [31:0] i_inst_id,
  input  logic [31:0] i_inst_ex,
  input  logic        i_mem_read_ex,
  output logic        o_load_use
);
  logic [4:0] w_rd_ex, w_rs1_id, w_rs2_id;
  logic [6:0] w_opc_id;
  logic       w_uses_rs2;
  logic       w_unused;

  assign w_rd_ex  = i_inst_ex[11:7];
  assign w_rs1_id = i_inst_id[19:15];
  assign w_rs2_id = i_inst_id[24:20];
  assign w_opc_id = i_inst_id[6:0];

  // Only R-type, store and branch read rs2; elsewhere bits [24:20] are immediate.
  assign w_uses_rs2 = (w_opc_id == OPC_OP) || (w_opc_id == OPC_STORE) ||
                      (w_opc_id == OPC_BRANCH);

  assign o_load_use = i_mem_read_ex && (w_rd_ex != 5'd0) &&
                      ((w_rd_ex == w_rs1_id) || (w_uses_rs2 && (w_rd_ex == w_rs2_id)));

  assign w_unused = ^{i_inst_id[14:7], i_inst_id[31:25], i_inst_ex[6:0], i_inst_ex[31:12]};
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch flush, one-cycle
// load-use stall, saturating perf counters and a sticky memory-timeout flag.
module pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_data_ID,
  input  logic [31:0]      inst_data_EX,
  input  logic             MemRead_EX,
  input  logic             branch_taken_EX,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout,
  output logic [1:0]       state_o
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_e            r_state, w_next;
  logic              w_load_use, w_mem_wait, w_freeze;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout;

  hazard_detect u_hazard (
    .i_inst_id    (inst_data_ID),
    .i_inst_ex    (inst_data_EX),
    .i_mem_read_ex(MemRead_EX),
    .o_load_use   (w_load_use)
  );

  assign w_mem_wait = dmem_req_MEM && !dmem_ready;
  // Once in MEM_WAIT only dmem_ready can release the freeze.
  assign w_freeze   = (r_state == MEM_WAIT) ? !dmem_ready : w_mem_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN: begin
        if (w_mem_wait)           w_next = MEM_WAIT;
        else if (branch_taken_EX) w_next = RUN;
        else if (w_load_use)      w_next = LU_STALL;
      end
      LU_STALL: w_next = w_mem_wait ? MEM_WAIT : RUN;
      MEM_WAIT: if (dmem_ready) w_next = RUN;
      default:  w_next = RUN;
    endcase
  end

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    exmem_we     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    if (!rst_n) begin
      {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
      {ifid_flush, idex_bubble, memwb_bubble} = 3'b111;
    end else if (w_freeze) begin
      {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
      memwb_bubble = 1'b1;
    end else if (r_state != MEM_WAIT && branch_taken_EX) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (r_state == RUN && w_load_use) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (!pc_we && r_stall_cnt != '1)     r_stall_cnt <= r_stall_cnt + 1'b1;
      if (ifid_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
      if (w_freeze) begin
        if (r_wait_cnt != WAIT_W'(MAX_WAIT)) r_wait_cnt <= r_wait_cnt + 1'b1;
        if (32'(r_wait_cnt) + 32'd1 >= 32'(MAX_WAIT)) r_timeout <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign mem_timeout = r_timeout;
  assign state_o     = r_state;
endmodule
